// File: rtl/robot_pkg.sv
// Shared encodings for the pipe-cleaning robot controller: FSM states,
// sensor patterns over {head,left,barrier}, action codes and default limits.
package robot_pkg;

  localparam logic [2:0] ST_RESET      = 3'd0;
  localparam logic [2:0] ST_FIRST_MOVE = 3'd1;
  localparam logic [2:0] ST_SEARCH     = 3'd2;
  localparam logic [2:0] ST_ROTATE     = 3'd3;
  localparam logic [2:0] ST_FOLLOW     = 3'd4;
  localparam logic [2:0] ST_STANDBY    = 3'd5;
  localparam logic [2:0] ST_STUCK      = 3'd6;

  // Sensor patterns, bit order {head,left,barrier}
  localparam logic [2:0] PAT_LEFT_WALL  = 3'b010;
  localparam logic [2:0] PAT_LEFT_TRASH = 3'b011;
  localparam logic [2:0] PAT_CORNER     = 3'b110;

  localparam int DEF_MAX_TURNS  = 8;
  localparam int DEF_MAX_REMOVE = 16;
  localparam int DEF_STEP_W     = 8;

  typedef enum logic [1:0] {
    ACT_NONE,
    ACT_FRONT,
    ACT_TURN,
    ACT_REMOVE
  } action_t;

endpackage

// File: rtl/robot_limit_counter.sv
// Consecutive-event counter that saturates at LIMIT and flags when the
// limit has been reached, so the next event of the same kind can be refused.
module robot_limit_counter #(
  parameter int LIMIT = 8,
  localparam int CNT_W = $clog2(LIMIT + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic             at_limit,
  output logic [CNT_W-1:0] count
);

  assign at_limit = (count == CNT_W'(LIMIT));

  always_ff @(posedge clock) begin
    if (!reset)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (inc && !at_limit)
      count <= count + 1'b1;
  end

endmodule

// File: rtl/robot_ctrl_param.sv
// Left-wall-following pipe-cleaning controller with effort supervision
// (turn/remove limits trap into STUCK) and a saturating step odometer.
module robot_ctrl_param
  import robot_pkg::*;
#(
  parameter int MAX_TURNS  = DEF_MAX_TURNS,
  parameter int MAX_REMOVE = DEF_MAX_REMOVE,
  parameter int STEP_W     = DEF_STEP_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              head,
  input  logic              left,
  input  logic              under,
  input  logic              barrier,
  output logic              front,
  output logic              turn,
  output logic              remove,
  output logic              done,
  output logic              stuck,
  output logic [STEP_W-1:0] step_count
);

  localparam int TURN_W   = $clog2(MAX_TURNS + 1);
  localparam int REMOVE_W = $clog2(MAX_REMOVE + 1);

  logic [2:0]          state;
  logic [2:0]          state_nxt;
  logic [2:0]          pat;
  action_t             act;
  logic                turn_at_limit;
  logic                remove_at_limit;
  logic [TURN_W-1:0]   turn_cnt;
  logic [REMOVE_W-1:0] remove_cnt;

  assign pat = {head, left, barrier};

  always_comb begin
    state_nxt = state;
    act       = ACT_NONE;
    case (state)
      ST_RESET: state_nxt = ST_FIRST_MOVE;
      ST_STANDBY, ST_STUCK: state_nxt = state;
      default: begin
        // Exit detection is masked while the robot is still leaving the dock
        if (under && (state != ST_FIRST_MOVE)) begin
          state_nxt = ST_STANDBY;
        end else if (head && barrier) begin
          state_nxt = ST_STANDBY;
        end else begin
          case (state)
            ST_FIRST_MOVE: begin
              if (pat == PAT_LEFT_WALL) begin
                state_nxt = ST_SEARCH;
                act       = ACT_FRONT;
              end else if (pat == PAT_LEFT_TRASH) begin
                act       = ACT_REMOVE;
              end else begin
                act       = ACT_TURN;
              end
            end
            ST_SEARCH: begin
              case (pat)
                PAT_LEFT_WALL:  act = ACT_FRONT;
                PAT_CORNER: begin
                  state_nxt = ST_ROTATE;
                  act       = ACT_TURN;
                end
                PAT_LEFT_TRASH: begin
                  state_nxt = ST_FOLLOW;
                  act       = ACT_REMOVE;
                end
                default: begin
                  state_nxt = ST_FOLLOW;
                  act       = ACT_TURN;
                end
              endcase
            end
            ST_ROTATE: begin
              if (pat == PAT_LEFT_WALL) begin
                state_nxt = ST_SEARCH;
                act       = ACT_FRONT;
              end else if (pat == PAT_LEFT_TRASH) begin
                state_nxt = ST_FOLLOW;
                act       = ACT_REMOVE;
              end else begin
                act       = ACT_TURN;
              end
            end
            ST_FOLLOW: begin
              if (!head && barrier) begin
                act       = ACT_REMOVE;
              end else if (!head) begin
                state_nxt = ST_SEARCH;
                act       = ACT_FRONT;
              end else if (left) begin
                state_nxt = ST_ROTATE;
                act       = ACT_TURN;
              end else begin
                act       = ACT_TURN;
              end
            end
            default: state_nxt = ST_RESET;
          endcase
        end
      end
    endcase
    // An action that would exceed its effort budget is suppressed and traps
    if ((act == ACT_TURN && turn_at_limit) || (act == ACT_REMOVE && remove_at_limit)) begin
      state_nxt = ST_STUCK;
      act       = ACT_NONE;
    end
  end

  assign front  = (act == ACT_FRONT);
  assign turn   = (act == ACT_TURN);
  assign remove = (act == ACT_REMOVE);
  assign done   = (state == ST_STANDBY);
  assign stuck  = (state == ST_STUCK);

  always_ff @(posedge clock) begin
    if (!reset)
      state <= ST_RESET;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clock) begin
    if (!reset)
      step_count <= '0;
    else if (front && (step_count != '1))
      step_count <= step_count + 1'b1;
  end

  robot_limit_counter #(.LIMIT(MAX_TURNS)) u_turn_cnt (
    .clock    (clock),
    .reset    (reset),
    .inc      (turn),
    .clr      (front | remove),
    .at_limit (turn_at_limit),
    .count    (turn_cnt)
  );

  robot_limit_counter #(.LIMIT(MAX_REMOVE)) u_remove_cnt (
    .clock    (clock),
    .reset    (reset),
    .inc      (remove),
    .clr      (front | turn),
    .at_limit (remove_at_limit),
    .count    (remove_cnt)
  );

  a_turn_bound:   assert property (@(posedge clock) turn_cnt <= TURN_W'(MAX_TURNS));
  a_remove_bound: assert property (@(posedge clock) remove_cnt <= REMOVE_W'(MAX_REMOVE));
  a_one_action:   assert property (@(posedge clock) $onehot0({front, turn, remove}));

endmodule
